treelut_ensemble_scheduler: RTL and testbench

- Time-multiplexed controller for a tree-ensemble classifier.
- Latches one feature vector, then steps a shared combinational tree datapath through every tree, one tree per cycle, in class-major order.
- Accumulates leaf values into per-class scores and tracks a running argmax.
- Returns the winning class and its score over a valid/ready handshake. Sits between the feature front-end and the result sink.

---
 rtl/treelut_ensemble_scheduler.sv | 167 ++++++++++++++++
 tb/tb_treelut_ensemble_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/treelut_ensemble_scheduler.sv
// -----------------------------------------------------------------------------
// treelut_ensemble_scheduler
//
// Time-multiplexed controller for a tree-ensemble classifier. One feature
// vector is latched, then a shared combinational tree datapath is stepped
// through every tree (one per cycle, class-major order). Leaf values are
// summed per class and a running argmax (ties keep the lower class) picks the
// result, which is returned over a valid/ready handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   feature vector offered
//   in_ready   out  scheduler can accept (IDLE only)
//   in_feat    in   feature vector
//   tree_feat  out  latched features to the shared tree datapath
//   tree_idx   out  tree selected this cycle (holds outside EVAL)
//   tree_en    out  tree_idx valid; tree_leaf sampled this cycle
//   tree_leaf  in   combinational leaf value for tree_idx
//   out_valid  out  result available
//   out_ready  in   sink accepts result
//   out_class  out  argmax class
//   out_score  out  score of out_class
// -----------------------------------------------------------------------------
module treelut_ensemble_scheduler #(
   parameter int FEAT_W          = 186,
   parameter int LEAF_W          = 3,
   parameter int NUM_CLASSES     = 5,
   parameter int TREES_PER_CLASS = 4,
   parameter int TREE_IDX_W      = $clog2(NUM_CLASSES*TREES_PER_CLASS),
   parameter int CLASS_W         = $clog2(NUM_CLASSES),
   parameter int SCORE_W         = LEAF_W + $clog2(TREES_PER_CLASS) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FEAT_W-1:0]     in_feat,
   output logic [FEAT_W-1:0]     tree_feat,
   output logic [TREE_IDX_W-1:0] tree_idx,
   output logic                  tree_en,
   input  logic [LEAF_W-1:0]     tree_leaf,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CLASS_W-1:0]    out_class,
   output logic [SCORE_W-1:0]    out_score
);

   localparam int NUM_TREES = NUM_CLASSES * TREES_PER_CLASS;
   localparam int K_W       = (TREES_PER_CLASS > 1) ? $clog2(TREES_PER_CLASS) : 1;

   localparam logic [K_W-1:0]        K_LAST   = K_W'(TREES_PER_CLASS - 1);
   localparam logic [TREE_IDX_W-1:0] IDX_LAST = TREE_IDX_W'(NUM_TREES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [K_W-1:0]     k_cnt;
   logic [CLASS_W-1:0] cls_cnt;
   logic [SCORE_W-1:0] acc;
   logic [SCORE_W-1:0] best_score;
   logic [CLASS_W-1:0] best_class;

   logic [SCORE_W-1:0] acc_next;
   logic               class_done;
   logic               take_best;
   logic [SCORE_W-1:0] best_score_nxt;
   logic [CLASS_W-1:0] best_class_nxt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      tree_en   = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = EVAL;
         end
         EVAL: begin
            tree_en = 1'b1;
            if (tree_idx == IDX_LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulate and argmax update; strict '>' keeps the lower class on ties,
   // and the first class always seeds the running best.
   always_comb begin
      acc_next       = acc + SCORE_W'(tree_leaf);
      class_done     = (k_cnt == K_LAST);
      take_best      = class_done && ((cls_cnt == '0) || (acc_next > best_score));
      best_score_nxt = take_best ? acc_next : best_score;
      best_class_nxt = take_best ? cls_cnt  : best_class;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tree_feat  <= '0;
         tree_idx   <= '0;
         k_cnt      <= '0;
         cls_cnt    <= '0;
         acc        <= '0;
         best_score <= '0;
         best_class <= '0;
         out_class  <= '0;
         out_score  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  tree_feat  <= in_feat;
                  tree_idx   <= '0;
                  k_cnt      <= '0;
                  cls_cnt    <= '0;
                  acc        <= '0;
                  best_score <= '0;
                  best_class <= '0;
               end
            end
            EVAL: begin
               best_score <= best_score_nxt;
               best_class <= best_class_nxt;
               if (class_done) begin
                  acc     <= '0;
                  k_cnt   <= '0;
                  cls_cnt <= cls_cnt + CLASS_W'(1);
               end else begin
                  acc     <= acc_next;
                  k_cnt   <= k_cnt + K_W'(1);
               end
               // tree_idx parks on the last tree; the result is captured
               // from the updated best so the final class is included.
               if (tree_idx != IDX_LAST) begin
                  tree_idx <= tree_idx + TREE_IDX_W'(1);
               end else begin
                  out_class <= best_class_nxt;
                  out_score <= best_score_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_treelut_ensemble_scheduler.sv
module tb_treelut_ensemble_scheduler;

   localparam int FEAT_W  = 186;
   localparam int LEAF_W  = 3;
   localparam int NC      = 5;
   localparam int TPC     = 4;
   localparam int NT      = NC * TPC;
   localparam int IDX_W   = $clog2(NT);
   localparam int CLASS_W = $clog2(NC);
   localparam int SCORE_W = LEAF_W + $clog2(TPC) + 1;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [FEAT_W-1:0]  in_feat;
   logic [FEAT_W-1:0]  tree_feat;
   logic [IDX_W-1:0]   tree_idx;
   logic               tree_en;
   logic [LEAF_W-1:0]  tree_leaf;
   logic               out_valid;
   logic               out_ready;
   logic [CLASS_W-1:0] out_class;
   logic [SCORE_W-1:0] out_score;

   logic [LEAF_W-1:0]  leaf_tab [NT];

   int checks = 0;
   int errors = 0;

   treelut_ensemble_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_feat   (in_feat),
      .tree_feat (tree_feat),
      .tree_idx  (tree_idx),
      .tree_en   (tree_en),
      .tree_leaf (tree_leaf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_score (out_score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural tree datapath: leaf value looked up from the table
   always_comb begin
      tree_leaf = '0;
      if (int'(tree_idx) < NT) tree_leaf = leaf_tab[int'(tree_idx)];
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FEAT_W-1:0] rand_feat();
      logic [191:0] r;
      for (int w = 0; w < 6; w++) r[w*32 +: 32] = $urandom;
      return r[FEAT_W-1:0];
   endfunction

   // Reference: per-class sums, first class with the highest sum wins
   task automatic model(output int cls, output int sc);
      int best;
      int s;
      best = -1;
      cls  = 0;
      for (int c = 0; c < NC; c++) begin
         s = 0;
         for (int k = 0; k < TPC; k++) s += int'(leaf_tab[c*TPC + k]);
         if (s > best) begin
            best = s;
            cls  = c;
         end
      end
      sc = best;
   endtask

   task automatic set_leaf(input int mode);
      for (int t = 0; t < NT; t++) begin
         case (mode)
            0:       leaf_tab[t] = 3'd1;
            1:       leaf_tab[t] = (t >= 12 && t <= 15) ? 3'd7 : 3'd0;
            2:       leaf_tab[t] = ((t >= 8 && t <= 11) || t >= 16) ? 3'd3 : 3'd1;
            default: leaf_tab[t] = LEAF_W'($urandom_range(0, 7));
         endcase
      end
   endtask

   // Present a vector and wait (bounded) until the scheduler is ready;
   // on return the next rising edge is the input handshake.
   task automatic offer(input logic [FEAT_W-1:0] feat);
      int n;
      in_feat  = feat;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", in_ready, 1'b1);
   endtask

   // Handshake edge, then the whole EVAL window and the first DONE cycle
   task automatic eval(input logic [FEAT_W-1:0] feat, input bit toggle,
                       input int exp_cls, input int exp_sc);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < NT; i++) begin
         chk("eval_tree_en", tree_en, 1'b1);
         chk("eval_tree_idx", tree_idx, i);
         chk("eval_out_valid", out_valid, 1'b0);
         chk("eval_in_ready", in_ready, 1'b0);
         chk("eval_tree_feat", tree_feat, feat);
         if (toggle) in_feat = rand_feat();
         @(posedge clk); #1;
      end
      chk("done_out_valid", out_valid, 1'b1);
      chk("done_tree_en", tree_en, 1'b0);
      chk("done_out_class", out_class, exp_cls);
      chk("done_out_score", out_score, exp_sc);
      chk("done_tree_feat", tree_feat, feat);
   endtask

   // Hold the result for 'hold' cycles, then complete the out handshake.
   // Optionally a next vector is offered while still in DONE.
   task automatic drain(input int hold, input logic [FEAT_W-1:0] feat,
                        input int exp_cls, input int exp_sc,
                        input bit nxt_valid, input logic [FEAT_W-1:0] nxt_feat);
      if (nxt_valid) begin
         in_valid = 1'b1;
         in_feat  = nxt_feat;
      end
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", out_valid, 1'b1);
         chk("hold_out_class", out_class, exp_cls);
         chk("hold_out_score", out_score, exp_sc);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_tree_feat", tree_feat, feat);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_out_valid", out_valid, 1'b0);
      chk("post_in_ready", in_ready, 1'b1);
      chk("post_tree_feat", tree_feat, feat);
   endtask

   initial begin
      int ec, es, ec2, es2;
      logic [FEAT_W-1:0] f, f2;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_feat   = '0;
      out_ready = 1'b0;
      set_leaf(0);

      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_tree_en", tree_en, 1'b0);
      chk("rst_tree_idx", tree_idx, 0);
      chk("rst_tree_feat", tree_feat, 0);
      chk("rst_out_class", out_class, 0);
      chk("rst_out_score", out_score, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // All leaves 1: five-way tie at 4, class 0 wins
      set_leaf(0);
      f = rand_feat();
      offer(f);
      eval(f, 1'b0, 0, 4);
      drain(0, f, 0, 4, 1'b0, '0);
      chk("tree_idx_parked", tree_idx, NT - 1);

      // Only class 3 scores
      set_leaf(1);
      f = rand_feat();
      offer(f);
      eval(f, 1'b0, 3, 28);
      drain(0, f, 3, 28, 1'b0, '0);

      // Classes 2 and 4 tie at 12, lower wins
      set_leaf(2);
      f = rand_feat();
      offer(f);
      eval(f, 1'b0, 2, 12);
      drain(0, f, 2, 12, 1'b0, '0);

      // Back-pressure with a second vector waiting, then accepted next cycle
      set_leaf(3);
      model(ec, es);
      f = rand_feat();
      offer(f);
      eval(f, 1'b0, ec, es);
      set_leaf(3);
      model(ec2, es2);
      f2 = rand_feat();
      drain(10, f, ec, es, 1'b1, f2);
      eval(f2, 1'b0, ec2, es2);
      drain(0, f2, ec2, es2, 1'b0, '0);

      // in_feat toggling during EVAL must not disturb tree_feat
      set_leaf(3);
      model(ec, es);
      f = rand_feat();
      offer(f);
      eval(f, 1'b1, ec, es);
      drain(1, f, ec, es, 1'b0, '0);

      // Reset in the middle of EVAL
      set_leaf(0);
      f = rand_feat();
      offer(f);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_tree_idx", tree_idx, 7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_tree_en", tree_en, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      chk("mid_rst_tree_feat", tree_feat, 0);
      chk("mid_rst_tree_idx", tree_idx, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after_rst_out_valid", out_valid, 1'b0);
      set_leaf(1);
      f = rand_feat();
      offer(f);
      eval(f, 1'b0, 3, 28);
      drain(0, f, 3, 28, 1'b0, '0);

      // Randomised leaf tables and back-pressure
      for (int r = 0; r < 8; r++) begin
         set_leaf(3);
         model(ec, es);
         f = rand_feat();
         offer(f);
         eval(f, ($urandom_range(0, 1) == 1), ec, es);
         drain(int'($urandom_range(0, 5)), f, ec, es, 1'b0, '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
